// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, interrupts and mret, then drives implicit CSR lanes.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets when mtvec[1:0] == 2'b01.
module trap_ctrl #(
  parameter logic [1:0] RESET_MODE = 2'b11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         exc_valid,
  input  logic [4:0]   exc_cause,
  input  logic [31:0]  exc_pc,
  input  logic [31:0]  exc_tval,
  input  logic         mret_valid,
  input  logic         irq_ext,
  input  logic         irq_timer,
  input  logic         irq_sw,
  input  logic         irq_pc_valid,
  input  logic [31:0]  irq_pc,
  output logic [3:0]   impl_read_enable,
  output logic [47:0]  impl_addrs_r,
  input  logic [127:0] impl_csr,
  output logic [3:0]   impl_write_enable,
  output logic [47:0]  impl_addrs_w,
  output logic [127:0] impl_write_data,
  output logic [1:0]   mode,
  output logic         busy,
  output logic         flush,
  output logic         redirect_valid,
  output logic [31:0]  redirect_pc
);

  typedef enum logic [1:0] {IDLE, TRAP_WR, MRET_WR, REDIRECT} state_t;
  state_t state_q, state_d;

  logic [31:0] mstatus, mtvec, mie, mepc;
  assign mstatus = impl_csr[31:0];
  assign mtvec   = impl_csr[63:32];
  assign mie     = impl_csr[95:64];
  assign mepc    = impl_csr[127:96];

  assign impl_read_enable = 4'b1111;
  assign impl_addrs_r     = {12'h341, 12'h304, 12'h305, 12'h300};
  assign impl_addrs_w     = {12'h343, 12'h342, 12'h341, 12'h300};

  logic       irq_take;
  logic [3:0] irq_code;
  always_comb begin
    irq_take = 1'b0;
    irq_code = '0;
    if (irq_pc_valid && ((mode != 2'b11) || mstatus[3])) begin
      if (irq_ext && mie[11]) begin
        irq_take = 1'b1;
        irq_code = 4'd11;
      end else if (irq_sw && mie[3]) begin
        irq_take = 1'b1;
        irq_code = 4'd3;
      end else if (irq_timer && mie[7]) begin
        irq_take = 1'b1;
        irq_code = 4'd7;
      end
    end
  end

  logic take_exc, take_irq, take_mret;
  assign take_exc  = (state_q == IDLE) && exc_valid;
  assign take_irq  = (state_q == IDLE) && !exc_valid && irq_take;
  assign take_mret = (state_q == IDLE) && !exc_valid && !irq_take && mret_valid;

  logic [31:0] trap_base, trap_target;
  assign trap_base = {mtvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
  assign trap_target = (take_irq && mtvec[1:0] == 2'b01) ? trap_base + {26'b0, irq_code, 2'b00} : trap_base;
  logic unused_bits;
  assign unused_bits = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0], mepc[1:0], exc_pc[1:0], irq_pc[1:0]};
`else
  assign trap_target = trap_base;
  logic unused_bits;
  assign unused_bits = ^{mtvec[1:0], mie[31:12], mie[10:8], mie[6:4], mie[2:0], mepc[1:0], exc_pc[1:0], irq_pc[1:0]};
`endif

  // Target and resulting mode are captured at accept so later CSR changes cannot disturb them.
  logic [31:0] target_q;
  logic [1:0]  mode_next_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (take_exc || take_irq) state_d = TRAP_WR;
        else if (take_mret)       state_d = MRET_WR;
      end
      TRAP_WR, MRET_WR: state_d = REDIRECT;
      default:          state_d = IDLE;
    endcase
  end

  logic         busy_d, flush_d, redirect_valid_d;
  logic [31:0]  redirect_pc_d, ms_trap, ms_mret;
  logic [3:0]   we_d;
  logic [127:0] wdata_d;
  always_comb begin
    ms_trap = {mstatus[31:13], mode, mstatus[10:8], mstatus[3], mstatus[6:4], 1'b0, mstatus[2:0]};
    ms_mret = {mstatus[31:13], 2'b11, mstatus[10:8], 1'b1, mstatus[6:4], mstatus[7], mstatus[2:0]};
    busy_d           = (state_d != IDLE);
    flush_d          = (state_d == TRAP_WR) || (state_d == MRET_WR);
    redirect_valid_d = (state_d == REDIRECT);
    redirect_pc_d    = (state_d == REDIRECT) ? target_q : '0;
    we_d             = '0;
    wdata_d          = '0;
    if (take_exc) begin
      we_d    = 4'b1111;
      wdata_d = {exc_tval, {27'b0, exc_cause}, {exc_pc[31:2], 2'b00}, ms_trap};
    end else if (take_irq) begin
      we_d    = 4'b1111;
      wdata_d = {32'b0, {1'b1, 27'b0, irq_code}, {irq_pc[31:2], 2'b00}, ms_trap};
    end else if (take_mret) begin
      we_d    = 4'b0001;
      wdata_d = {96'b0, ms_mret};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      mode              <= RESET_MODE;
      busy              <= 1'b0;
      flush             <= 1'b0;
      redirect_valid    <= 1'b0;
      redirect_pc       <= '0;
      impl_write_enable <= '0;
      impl_write_data   <= '0;
      target_q          <= '0;
      mode_next_q       <= RESET_MODE;
    end else begin
      state_q           <= state_d;
      busy              <= busy_d;
      flush             <= flush_d;
      redirect_valid    <= redirect_valid_d;
      redirect_pc       <= redirect_pc_d;
      impl_write_enable <= we_d;
      impl_write_data   <= wdata_d;
      if (take_exc || take_irq) begin
        target_q    <= trap_target;
        mode_next_q <= 2'b11;
      end else if (take_mret) begin
        target_q    <= {mepc[31:2], 2'b00};
        mode_next_q <= (mstatus[12:11] == 2'b10) ? 2'b00 : mstatus[12:11];
      end
      if (state_q == TRAP_WR || state_q == MRET_WR) mode <= mode_next_q;
    end
  end

endmodule
